// File: rtl/seq_gen.sv
// -----------------------------------------------------------------------------
// seq_gen -- serial pattern transmitter
//
// Purpose:
//   On a start request in IDLE, latches a parallel pattern and sends it MSB-first
//   on x, one bit per clock. The effective MSB is pattern[L-1]. The pattern is
//   repeated R times. This block is the stimulus source for the sequence
//   detectors, and its x output drives the detector's serial input directly.
//
// Build option:
//   SEQ_GEN_GAP_EN  When defined, GAP idle-zero cycles (x=0, bit_vld=0, busy=1)
//                   are inserted between repetitions. When undefined,
//                   repetitions are sent back-to-back and GAP is unused.
//
// Parameters:
//   W      maximum pattern length in bits (W >= 2)
//   LEN_W  width of len; 2**LEN_W must exceed W
//   REP_W  width of reps
//   GAP    idle cycles between repetitions (SEQ_GEN_GAP_EN only)
//
// Ports:
//   clk      in   1      system clock, rising edge
//   reset    in   1      asynchronous reset, active-low
//   start    in   1      frame request, sampled only in IDLE
//   pattern  in   W      bits to send; pattern[len-1] goes out first
//   len      in   LEN_W  bits per repetition; 0 or >W means W
//   reps     in   REP_W  repetition count; 0 means 1
//   x        out  1      serial data (0 whenever bit_vld is 0)
//   bit_vld  out  1      x carries a pattern bit
//   busy     out  1      high from the first bit through the last bit, incl. gaps
//   done     out  1      one-cycle pulse after the last bit of the last repetition
// -----------------------------------------------------------------------------
module seq_gen #(
  parameter int W     = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             x,
  output logic             bit_vld,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
`ifdef SEQ_GEN_GAP_EN
  localparam logic [1:0] S_GAP  = 2'd3;
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;
`endif

  localparam logic [LEN_W-1:0] W_L = LEN_W'(W);

  // State and datapath registers
  logic [1:0]       state_q,    state_d;
  logic [W-1:0]     pat_q,      pat_d;      // pattern left-aligned so bit L-1 sits at MSB
  logic [W-1:0]     sh_q,       sh_d;       // bits of this repetition still to be sent
  logic [LEN_W-1:0] len_q,      len_d;      // effective length L
  logic [LEN_W-1:0] bit_cnt_q,  bit_cnt_d;  // bits remaining after the one on x
  logic [REP_W-1:0] rep_left_q, rep_left_d; // repetitions remaining after this one
  logic             x_q,        x_d;
  logic             vld_q,      vld_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
`ifdef SEQ_GEN_GAP_EN
  logic [GAP_W-1:0] gap_cnt_q,  gap_cnt_d;  // gap cycles remaining after this one
`endif

  // Decode the request inputs into effective length, alignment and repetitions
  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] shamt;
  logic [W-1:0]     pat_al;
  logic [REP_W-1:0] rep_left_init;

  assign len_eff       = (len == '0 || len > W_L) ? W_L : len;
  assign shamt         = W_L - len_eff;
  // Left-align so the first bit to send is always at the MSB; a plain shift
  // then walks the bits without a variable-index mux.
  assign pat_al        = pattern << shamt;
  assign rep_left_init = (reps == '0) ? '0 : reps - 1'b1;

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    sh_d       = sh_q;
    len_d      = len_q;
    bit_cnt_d  = bit_cnt_q;
    rep_left_d = rep_left_q;
    x_d        = x_q;
    vld_d      = vld_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef SEQ_GEN_GAP_EN
    gap_cnt_d  = gap_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        x_d    = 1'b0;
        vld_d  = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          pat_d      = pat_al;
          len_d      = len_eff;
          rep_left_d = rep_left_init;
          x_d        = pat_al[W-1];
          sh_d       = pat_al << 1;
          bit_cnt_d  = len_eff - 1'b1;
          vld_d      = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_SEND;
        end
      end

      S_SEND: begin
        if (bit_cnt_q != '0) begin
          // Next bit in the current repetition
          x_d       = sh_q[W-1];
          sh_d      = sh_q << 1;
          bit_cnt_d = bit_cnt_q - 1'b1;
        end else if (rep_left_q != '0) begin
          rep_left_d = rep_left_q - 1'b1;
`ifdef SEQ_GEN_GAP_EN
          if (GAP > 0) begin
            x_d       = 1'b0;
            vld_d     = 1'b0;
            gap_cnt_d = GAP_W'(GAP_M1);
            state_d   = S_GAP;
          end else begin
            x_d       = pat_q[W-1];
            sh_d      = pat_q << 1;
            bit_cnt_d = len_q - 1'b1;
          end
`else
          // Back-to-back: restart at the first bit with no idle cycle
          x_d       = pat_q[W-1];
          sh_d      = pat_q << 1;
          bit_cnt_d = len_q - 1'b1;
`endif
        end else begin
          // Last bit of the last repetition has been shown
          x_d     = 1'b0;
          vld_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FIN;
        end
      end

`ifdef SEQ_GEN_GAP_EN
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          x_d       = pat_q[W-1];
          sh_d      = pat_q << 1;
          bit_cnt_d = len_q - 1'b1;
          vld_d     = 1'b1;
          state_d   = S_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
`endif

      S_FIN: begin
        // done drops here; a start seen this cycle is not queued
        x_d     = 1'b0;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        x_d     = 1'b0;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pat_q      <= '0;
      sh_q       <= '0;
      len_q      <= '0;
      bit_cnt_q  <= '0;
      rep_left_q <= '0;
      x_q        <= 1'b0;
      vld_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      sh_q       <= sh_d;
      len_q      <= len_d;
      bit_cnt_q  <= bit_cnt_d;
      rep_left_q <= rep_left_d;
      x_q        <= x_d;
      vld_q      <= vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef SEQ_GEN_GAP_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  assign x       = x_q;
  assign bit_vld = vld_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_gen -- directed, self-checking bench for seq_gen.
// Each started frame pushes its expected per-cycle {x,bit_vld,busy,done}
// tuples into a queue. Every cycle pops one tuple (idle 0000 when the queue
// is empty) and compares it with the DUT outputs 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_seq_gen;
  localparam int W     = 8;
  localparam int LEN_W = 4;
  localparam int REP_W = 4;
  localparam int GAP   = 2;

  logic             clk     = 1'b0;
  logic             reset   = 1'b0;
  logic             start   = 1'b0;
  logic [W-1:0]     pattern = '0;
  logic [LEN_W-1:0] len     = '0;
  logic [REP_W-1:0] reps    = '0;
  logic             x, bit_vld, busy, done;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  seq_gen #(.W(W), .LEN_W(LEN_W), .REP_W(REP_W), .GAP(GAP)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .reps    (reps),
    .x       (x),
    .bit_vld (bit_vld),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got x/vld/busy/done=%b exp %b", tag, obs, exp);
    end
  endtask

  // Push the expected output sequence for one frame, including the done pulse
  task automatic push_frame(input logic [W-1:0] pat, input int l_in, input int r_in);
    int l;
    int r;
    l = (l_in == 0 || l_in > W) ? W : l_in;
    r = (r_in == 0) ? 1 : r_in;
    for (int ri = 0; ri < r; ri++) begin
      for (int bi = 0; bi < l; bi++)
        exp_q.push_back({pat[l-1-bi], 1'b1, 1'b1, 1'b0});
`ifdef SEQ_GEN_GAP_EN
      if (ri < r - 1)
        for (int gi = 0; gi < GAP; gi++)
          exp_q.push_back(4'b0010);
`endif
    end
    exp_q.push_back(4'b0001);
  endtask

  task automatic step(input string tag);
    logic [3:0] e;
    @(posedge clk);
    #1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
    check(tag, {x, bit_vld, busy, done}, e);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) step(tag);
    step({tag, "_idle"});
  endtask

  // Request a frame; the edge that samples start also shows the first bit
  task automatic start_frame(input string tag, input logic [W-1:0] pat,
                             input int l, input int r);
    pattern = pat;
    len     = LEN_W'(l);
    reps    = REP_W'(r);
    start   = 1'b1;
    push_frame(pat, l, r);
    step(tag);
    start   = 1'b0;
    $display("frame %s pattern=%h len=%0d reps=%0d", tag, pat, l, r);
  endtask

  initial begin
    // 1: reset held low while start/pattern toggle
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      start = 1'b1; pattern = 8'hFF; len = 4'd3; reps = 4'd2;
      #1 check("reset_a", {x, bit_vld, busy, done}, 4'b0000);
      @(negedge clk);
      start = 1'b0; pattern = 8'h5A;
      #1 check("reset_b", {x, bit_vld, busy, done}, 4'b0000);
    end
    @(negedge clk);
    reset = 1'b1;
    step("post_reset");
    step("post_reset");

    // 2: 7 bits of 0100_1110
    start_frame("len7", 8'b0100_1110, 7, 1);
    drain("len7");

    // 3: len=0 means W, reps=2 back-to-back
    start_frame("len0_r2", 8'hA5, 0, 2);
    drain("len0_r2");

    // 4: start re-pulsed mid-frame with new inputs is ignored
    start_frame("ignore", 8'hC3, 8, 1);
    step("ignore");
    step("ignore");
    start = 1'b1; pattern = 8'h00; len = 4'd2; reps = 4'd5;
    step("ignore");
    start = 1'b0;
    drain("ignore");

    // 5: async reset after the third bit, then a full frame
    start_frame("abort", 8'h96, 8, 1);
    step("abort");
    step("abort");
    #2 reset = 1'b0;
    #1 check("abort_async", {x, bit_vld, busy, done}, 4'b0000);
    exp_q.delete();
    step("abort_hold");
    @(negedge clk);
    reset = 1'b1;
    step("abort_idle");
    start_frame("after_abort", 8'h96, 8, 1);
    drain("after_abort");

    // 6: 3'b101, len 3, reps 2 (gap build inserts GAP zeros)
    start_frame("gap", 8'b0000_0101, 3, 2);
    drain("gap");

    // L==1 with three repetitions
    start_frame("len1_r3", 8'h01, 1, 3);
    drain("len1_r3");

    // len beyond W, reps==0
    start_frame("len12_r0", 8'h81, 12, 0);
    drain("len12_r0");

    // maximum repetition count
    start_frame("rmax", 8'h02, 2, 15);
    drain("rmax");

    // start held high across FIN re-triggers after one idle cycle
    pattern = 8'h02; len = 4'd2; reps = 4'd1; start = 1'b1;
    push_frame(8'h02, 2, 1);
    exp_q.push_back(4'b0000);
    push_frame(8'h02, 2, 1);
    for (int i = 0; i < 5; i++) step("retrig");
    start = 1'b0;
    $display("frame retrig pattern=02 len=2 reps=1 x2");
    drain("retrig");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
